// File: rtl/softmax_tile_driver.sv
// -----------------------------------------------------------------------------
// softmax_tile_driver
//
// Initiator side of the safe-softmax engine interface. A row of attention
// scores arrives as NUM-word tiles; each tile is registered and handed to the
// engine together with the running max / exp-sum carried from the previous
// tile. The engine's one-cycle valid returns the normalised tile and the
// updated max / sum. The result is presented downstream on a valid/ready port
// and the updated max / sum are fed back into the next tile.
//
// Optional feature (macro SOFTMAX_DRV_TIMEOUT_EN): watchdog on the RUN state.
// If the engine does not answer within TO_CYC cycles, start is dropped, the
// tile is discarded, the driver returns to IDLE and O_ERR latches high until
// reset or the next accepted row start. Without the macro O_ERR is tied 0.
//
// Ports:
//   I_CLK, I_RST          clock, synchronous active-high reset
//   I_ROW_START/TILES     row start pulse and tile count (1..MAX_TILES)
//   I_TILE_VLD/DATA       upstream tile (NUM signed D_W-bit words, flat)
//   O_TILE_RDY            driver accepts a tile
//   O_SM_START            engine start, held high while the engine computes
//   O_SM_DATA/X_MAX/EXP_SUM  registered tile and carried max / sum to engine
//   I_SM_VLD/DATA/X_MAX/EXP_SUM  engine result, valid for one cycle
//   O_OUT_VLD/DATA/X_MAX/EXP_SUM/LAST  downstream result port
//   I_OUT_RDY             downstream ready
//   O_BUSY                row in progress
//   O_ERR                 sticky watchdog abort (optional feature)
// -----------------------------------------------------------------------------
module softmax_tile_driver #(
  parameter int D_W       = 8,
  parameter int NUM       = 16,
  parameter int MAX_TILES = 8,
  parameter int TO_CYC    = 1024
) (
  input  logic                         I_CLK,
  input  logic                         I_RST,
  input  logic                         I_ROW_START,
  input  logic [$clog2(MAX_TILES+1)-1:0] I_ROW_TILES,
  input  logic                         I_TILE_VLD,
  input  logic [D_W*NUM-1:0]           I_TILE_DATA,
  output logic                         O_TILE_RDY,
  output logic                         O_SM_START,
  output logic [D_W*NUM-1:0]           O_SM_DATA,
  output logic [D_W-1:0]               O_SM_X_MAX,
  output logic [15:0]                  O_SM_EXP_SUM,
  input  logic [D_W-1:0]               I_SM_X_MAX,
  input  logic [15:0]                  I_SM_EXP_SUM,
  input  logic                         I_SM_VLD,
  input  logic [D_W*NUM-1:0]           I_SM_DATA,
  output logic                         O_OUT_VLD,
  output logic [D_W*NUM-1:0]           O_OUT_DATA,
  output logic [D_W-1:0]               O_OUT_X_MAX,
  output logic [15:0]                  O_OUT_EXP_SUM,
  output logic                         O_OUT_LAST,
  input  logic                         I_OUT_RDY,
  output logic                         O_BUSY,
  output logic                         O_ERR
);

  localparam int CW = $clog2(MAX_TILES + 1);
  localparam logic [CW-1:0]  MAX_T    = CW'(MAX_TILES);
  localparam logic [D_W-1:0] MOST_NEG = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EMIT,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] tile_cnt;
  logic [CW-1:0] tile_idx;

  wire row_ok = (I_ROW_TILES != '0) && (I_ROW_TILES <= MAX_T);

`ifdef SOFTMAX_DRV_TIMEOUT_EN
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [TW-1:0] to_cnt;
  wire to_hit = (to_cnt == TW'(TO_CYC - 1));
`else
  // Parameter kept for interface compatibility; the watchdog is not built.
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC > 0);
  assign O_ERR = 1'b0;
`endif

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of order.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state         <= S_IDLE;
      tile_cnt      <= '0;
      tile_idx      <= '0;
      O_TILE_RDY    <= 1'b0;
      O_SM_START    <= 1'b0;
      O_SM_DATA     <= '0;
      O_SM_X_MAX    <= MOST_NEG;
      O_SM_EXP_SUM  <= '0;
      O_OUT_VLD     <= 1'b0;
      O_OUT_DATA    <= '0;
      O_OUT_X_MAX   <= '0;
      O_OUT_EXP_SUM <= '0;
      O_OUT_LAST    <= 1'b0;
      O_BUSY        <= 1'b0;
`ifdef SOFTMAX_DRV_TIMEOUT_EN
      to_cnt        <= '0;
      O_ERR         <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (I_ROW_START && row_ok) begin
            tile_cnt     <= I_ROW_TILES;
            tile_idx     <= '0;
            O_SM_X_MAX   <= MOST_NEG;
            O_SM_EXP_SUM <= '0;
            O_TILE_RDY   <= 1'b1;
            O_BUSY       <= 1'b1;
            state        <= S_LOAD;
`ifdef SOFTMAX_DRV_TIMEOUT_EN
            O_ERR        <= 1'b0;
`endif
          end
        end

        S_LOAD: begin
          if (I_TILE_VLD) begin
            O_SM_DATA  <= I_TILE_DATA;
            O_SM_START <= 1'b1;
            O_TILE_RDY <= 1'b0;
            state      <= S_RUN;
`ifdef SOFTMAX_DRV_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end

        S_RUN: begin
          if (I_SM_VLD) begin
            O_OUT_DATA    <= I_SM_DATA;
            O_OUT_X_MAX   <= I_SM_X_MAX;
            O_OUT_EXP_SUM <= I_SM_EXP_SUM;
            // Returned max / sum become the carry-in for the next tile.
            O_SM_X_MAX    <= I_SM_X_MAX;
            O_SM_EXP_SUM  <= I_SM_EXP_SUM;
            // Dropping start on the valid edge keeps the engine from
            // re-triggering on the same tile.
            O_SM_START    <= 1'b0;
            O_OUT_VLD     <= 1'b1;
            O_OUT_LAST    <= (tile_idx == tile_cnt - CW'(1));
            state         <= S_EMIT;
`ifdef SOFTMAX_DRV_TIMEOUT_EN
          end else if (to_hit) begin
            O_SM_START <= 1'b0;
            O_ERR      <= 1'b1;
            O_BUSY     <= 1'b0;
            state      <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
`endif
          end
        end

        S_EMIT: begin
          if (I_OUT_RDY) begin
            O_OUT_VLD <= 1'b0;
            if (O_OUT_LAST) begin
              O_BUSY <= 1'b0;
              state  <= S_IDLE;
            end else begin
              tile_idx <= tile_idx + CW'(1);
              state    <= S_GAP;
            end
          end
        end

        // One spare cycle so start stays low for at least two cycles between
        // consecutive tiles (EMIT handshake cycle + GAP).
        S_GAP: begin
          O_TILE_RDY <= 1'b1;
          state      <= S_LOAD;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_tile_driver.sv
// -----------------------------------------------------------------------------
// tb_softmax_tile_driver
//
// Self-checking bench for softmax_tile_driver. A behavioural engine responds to
// start after a programmable latency (new max = signed max of carry-in and the
// tile words, new sum = carry-in + 0x0200, quotient = word ^ 0x10) and watches
// start spacing. Directed rows come from a constant table; random rows are
// checked against a per-row reference computed with plain loops.
// -----------------------------------------------------------------------------
module tb_softmax_tile_driver;

  localparam int D_W = 8;
  localparam int NUM = 16;
  localparam int MAX_TILES = 8;
  localparam int W = D_W * NUM;
  localparam int CW = $clog2(MAX_TILES + 1);

  logic          I_CLK, I_RST;
  logic          I_ROW_START;
  logic [CW-1:0] I_ROW_TILES;
  logic          I_TILE_VLD;
  logic [W-1:0]  I_TILE_DATA;
  logic          O_TILE_RDY, O_SM_START;
  logic [W-1:0]  O_SM_DATA;
  logic [7:0]    O_SM_X_MAX;
  logic [15:0]   O_SM_EXP_SUM;
  logic [7:0]    I_SM_X_MAX;
  logic [15:0]   I_SM_EXP_SUM;
  logic          I_SM_VLD;
  logic [W-1:0]  I_SM_DATA;
  logic          O_OUT_VLD;
  logic [W-1:0]  O_OUT_DATA;
  logic [7:0]    O_OUT_X_MAX;
  logic [15:0]   O_OUT_EXP_SUM;
  logic          O_OUT_LAST, I_OUT_RDY, O_BUSY, O_ERR;

  softmax_tile_driver #(.D_W(D_W), .NUM(NUM), .MAX_TILES(MAX_TILES), .TO_CYC(64)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST),
    .I_ROW_START(I_ROW_START), .I_ROW_TILES(I_ROW_TILES),
    .I_TILE_VLD(I_TILE_VLD), .I_TILE_DATA(I_TILE_DATA), .O_TILE_RDY(O_TILE_RDY),
    .O_SM_START(O_SM_START), .O_SM_DATA(O_SM_DATA),
    .O_SM_X_MAX(O_SM_X_MAX), .O_SM_EXP_SUM(O_SM_EXP_SUM),
    .I_SM_X_MAX(I_SM_X_MAX), .I_SM_EXP_SUM(I_SM_EXP_SUM),
    .I_SM_VLD(I_SM_VLD), .I_SM_DATA(I_SM_DATA),
    .O_OUT_VLD(O_OUT_VLD), .O_OUT_DATA(O_OUT_DATA),
    .O_OUT_X_MAX(O_OUT_X_MAX), .O_OUT_EXP_SUM(O_OUT_EXP_SUM),
    .O_OUT_LAST(O_OUT_LAST), .I_OUT_RDY(I_OUT_RDY),
    .O_BUSY(O_BUSY), .O_ERR(O_ERR)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- engine
  logic        eng_vld = 1'b0, tb_vld = 1'b0;
  bit          eng_mute = 1'b0;
  bit          eng_done = 1'b0;
  int          eng_lat = 3;
  int          eng_cnt = 0;
  logic [W-1:0] eng_in;
  logic [7:0]  eng_max_in;
  logic [15:0] eng_sum_in;
  logic [7:0]  seen_max[$];
  logic [15:0] seen_sum[$];
  int          viol = 0;
  int          low_cnt = 100;
  bit          prev_start = 1'b0;

  assign I_SM_VLD = eng_vld | tb_vld;

  always @(negedge I_CLK) begin
    logic signed [7:0] m;
    if (I_RST) begin
      eng_vld  = 1'b0;
      eng_cnt  = 0;
      eng_done = 1'b0;
    end else begin
      if (eng_vld) begin
        if (O_SM_START) viol++;      // start must be low the cycle after valid
        eng_vld  = 1'b0;
        eng_done = 1'b1;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          m = $signed(eng_max_in);
          for (int i = 0; i < NUM; i++) begin
            if ($signed(eng_in[i*8 +: 8]) > m) m = $signed(eng_in[i*8 +: 8]);
            I_SM_DATA[i*8 +: 8] = eng_in[i*8 +: 8] ^ 8'h10;
          end
          I_SM_X_MAX   = m;
          I_SM_EXP_SUM = eng_sum_in + 16'h0200;
          eng_vld      = 1'b1;
        end
      end else if (O_SM_START && !eng_done && !eng_mute) begin
        eng_in     = O_SM_DATA;
        eng_max_in = O_SM_X_MAX;
        eng_sum_in = O_SM_EXP_SUM;
        seen_max.push_back(O_SM_X_MAX);
        seen_sum.push_back(O_SM_EXP_SUM);
        eng_cnt = eng_lat;
      end
      if (!O_SM_START) eng_done = 1'b0;
    end
    if (O_SM_START && !prev_start && low_cnt < 2) viol++;
    if (O_SM_START) low_cnt = 0; else low_cnt++;
    prev_start = O_SM_START;
  end

  // ------------------------------------------------------- row expectations
  logic [W-1:0]  row_tiles[MAX_TILES];
  logic [W-1:0]  exp_data[MAX_TILES];
  logic [7:0]    exp_in_max[MAX_TILES], exp_out_max[MAX_TILES];
  logic [15:0]   exp_in_sum[MAX_TILES], exp_out_sum[MAX_TILES];

  // Reference: running max over every word of the row seen so far (seeded
  // at -128), sum grows by 0x0200 per tile, quotients are word ^ 0x10.
  task automatic build_ref(input int n);
    int rm;
    rm = -128;
    for (int k = 0; k < n; k++) begin
      exp_in_max[k] = 8'(rm);
      exp_in_sum[k] = 16'(k * 512);
      for (int i = 0; i < NUM; i++) begin
        int v;
        v = int'($signed(row_tiles[k][i*8 +: 8]));
        if (v > rm) rm = v;
        exp_data[k][i*8 +: 8] = row_tiles[k][i*8 +: 8] ^ 8'h10;
      end
      exp_out_max[k] = 8'(rm);
      exp_out_sum[k] = 16'((k + 1) * 512);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tile_rdy"}, O_TILE_RDY, 0);
    check({tag, "_sm_start"}, O_SM_START, 0);
    check({tag, "_sm_data"},  O_SM_DATA, 0);
    check({tag, "_sm_xmax"},  O_SM_X_MAX, 8'h80);
    check({tag, "_sm_sum"},   O_SM_EXP_SUM, 0);
    check({tag, "_out_vld"},  O_OUT_VLD, 0);
    check({tag, "_out_data"}, O_OUT_DATA, 0);
    check({tag, "_out_xmax"}, O_OUT_X_MAX, 0);
    check({tag, "_out_sum"},  O_OUT_EXP_SUM, 0);
    check({tag, "_out_last"}, O_OUT_LAST, 0);
    check({tag, "_busy"},     O_BUSY, 0);
    check({tag, "_err"},      O_ERR, 0);
  endtask

  task automatic pulse_row(input int n);
    I_ROW_START = 1'b1;
    I_ROW_TILES = CW'(n);
    @(negedge I_CLK);
    I_ROW_START = 1'b0;
  endtask

  // Wait in LOAD for ready, then hand over one tile; returns 0 on timeout.
  task automatic feed_tile(input logic [W-1:0] data, output bit ok);
    int t = 0;
    while (!O_TILE_RDY && t < 100) begin @(negedge I_CLK); t++; end
    check("tile_rdy_wait", O_TILE_RDY, 1);
    ok = O_TILE_RDY;
    if (!ok) return;
    I_TILE_VLD  = 1'b1;
    I_TILE_DATA = data;
    @(negedge I_CLK);
    I_TILE_VLD  = 1'b0;
    I_TILE_DATA = {4{$urandom()}};
  endtask

  task automatic run_row(input int n, input int hold_first, input bit rand_hold);
    bit ok;
    pulse_row(n);
    check("row_accept", {O_BUSY, O_TILE_RDY}, 2'b11);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      int hold;
      bit stable;
      logic [W-1:0] snap;
      feed_tile(row_tiles[k], ok);
      if (!ok) return;
      while (!O_OUT_VLD && t < 200) begin @(negedge I_CLK); t++; end
      check("out_vld_wait", O_OUT_VLD, 1);
      if (!O_OUT_VLD) return;
      check("out_data", O_OUT_DATA, exp_data[k]);
      check("out_xmax", O_OUT_X_MAX, exp_out_max[k]);
      check("out_sum",  O_OUT_EXP_SUM, exp_out_sum[k]);
      check("out_last", O_OUT_LAST, (k == n - 1));
      check("eng_seen_cnt", seen_max.size(), 1);
      if (seen_max.size() > 0) begin
        check("eng_in_xmax", seen_max.pop_front(), exp_in_max[k]);
        check("eng_in_sum",  seen_sum.pop_front(), exp_in_sum[k]);
      end
      hold = (k == 0) ? hold_first : (rand_hold ? int'($urandom_range(0, 3)) : 0);
      snap = O_OUT_DATA;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge I_CLK);
        if (!O_OUT_VLD || O_OUT_DATA !== snap || O_OUT_X_MAX !== exp_out_max[k] ||
            O_OUT_EXP_SUM !== exp_out_sum[k] || O_TILE_RDY || O_SM_START)
          stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", stable, 1);
      I_OUT_RDY = 1'b1;
      @(negedge I_CLK);
      I_OUT_RDY = 1'b0;
      check("out_vld_drop", O_OUT_VLD, 0);
    end
    check("row_idle", O_BUSY, 0);
  endtask

  // ------------------------------------------------------ directed vectors
  typedef struct {
    int          n;
    logic [7:0]  fill;
    logic [7:0]  peak[3];
    logic [7:0]  in_max[3];
    logic [7:0]  out_max[3];
    logic [15:0] out_sum[3];
    logic [7:0]  dfill;
    logic [7:0]  dpeak[3];
  } vec_t;

  vec_t tbl[3];

  initial begin
    bit ok;
    tbl[0] = '{n: 1, fill: 8'h00, peak: '{8'h00, 8'h00, 8'h00},
               in_max: '{8'h80, 8'h00, 8'h00}, out_max: '{8'h00, 8'h00, 8'h00},
               out_sum: '{16'h0200, 16'h0, 16'h0}, dfill: 8'h10,
               dpeak: '{8'h10, 8'h00, 8'h00}};
    tbl[1] = '{n: 3, fill: 8'hF0, peak: '{8'h05, 8'h07, 8'h03},
               in_max: '{8'h80, 8'h05, 8'h07}, out_max: '{8'h05, 8'h07, 8'h07},
               out_sum: '{16'h0200, 16'h0400, 16'h0600}, dfill: 8'hE0,
               dpeak: '{8'h15, 8'h17, 8'h13}};
    tbl[2] = '{n: 2, fill: 8'h80, peak: '{8'h7F, 8'h81, 8'h00},
               in_max: '{8'h80, 8'h7F, 8'h00}, out_max: '{8'h7F, 8'h7F, 8'h00},
               out_sum: '{16'h0200, 16'h0400, 16'h0}, dfill: 8'h90,
               dpeak: '{8'h6F, 8'h91, 8'h00}};

    I_RST = 1'b1; I_ROW_START = 1'b0; I_ROW_TILES = '0; I_TILE_VLD = 1'b0;
    I_TILE_DATA = '0; I_OUT_RDY = 1'b0;
    I_SM_X_MAX = '0; I_SM_EXP_SUM = '0; I_SM_DATA = '0;
    repeat (3) @(negedge I_CLK);
    I_RST = 1'b0;
    check_reset_vals("rst");

    // Directed rows from the table.
    for (int v = 0; v < 3; v++) begin
      eng_lat = 2 + v;
      for (int k = 0; k < tbl[v].n; k++) begin
        row_tiles[k] = {NUM{tbl[v].fill}};
        row_tiles[k][7:0] = tbl[v].peak[k];
        exp_data[k] = {NUM{tbl[v].dfill}};
        exp_data[k][7:0] = tbl[v].dpeak[k];
        exp_in_max[k]  = tbl[v].in_max[k];
        exp_out_max[k] = tbl[v].out_max[k];
        exp_out_sum[k] = tbl[v].out_sum[k];
        exp_in_sum[k]  = (k == 0) ? 16'h0 : tbl[v].out_sum[k-1];
      end
      run_row(tbl[v].n, 0, 1'b0);
    end

    // Backpressure: first output held 20 cycles.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM; i++) row_tiles[k][i*8 +: 8] = 8'($urandom_range(0, 255));
    build_ref(2);
    run_row(2, 20, 1'b0);

    // Illegal tile counts are ignored.
    pulse_row(0);
    check("cnt0_ignored", {O_BUSY, O_TILE_RDY}, 2'b00);
    pulse_row(MAX_TILES + 1);
    check("cnt9_ignored", {O_BUSY, O_TILE_RDY}, 2'b00);

    // Engine valid in IDLE is ignored.
    tb_vld = 1'b1;
    @(negedge I_CLK);
    tb_vld = 1'b0;
    check("smvld_idle_ignored", {O_OUT_VLD, O_BUSY}, 2'b00);

    // Row start and tile valid during RUN are ignored, then reset in RUN.
    eng_mute = 1'b1;
    pulse_row(3);
    feed_tile({NUM{8'h3C}}, ok);
    check("run_start", O_SM_START, 1);
    check("run_data", O_SM_DATA, {NUM{8'h3C}});
    pulse_row(1);
    check("rowstart_in_run", {O_BUSY, O_SM_START, O_TILE_RDY}, 3'b110);
    I_TILE_VLD = 1'b1;
    I_TILE_DATA = {NUM{8'hA5}};
    @(negedge I_CLK);
    I_TILE_VLD = 1'b0;
    check("tilevld_in_run", O_SM_DATA, {NUM{8'h3C}});
    check("tilevld_in_run_start", O_SM_START, 1);
    I_RST = 1'b1;
    @(negedge I_CLK);
    check_reset_vals("rst_run");
    I_RST = 1'b0;
    eng_mute = 1'b0;
    seen_max.delete();
    seen_sum.delete();
    repeat (3) @(negedge I_CLK);

    // Random rows against the reference model.
    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(1, MAX_TILES));
      eng_lat = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++)
        for (int i = 0; i < NUM; i++) row_tiles[k][i*8 +: 8] = 8'($urandom_range(0, 255));
      build_ref(n);
      run_row(n, int'($urandom_range(0, 3)), 1'b1);
    end

`ifdef SOFTMAX_DRV_TIMEOUT_EN
    // Engine never answers: abort 64 cycles after RUN entry.
    eng_mute = 1'b1;
    pulse_row(1);
    feed_tile({NUM{8'h01}}, ok);
    repeat (63) @(negedge I_CLK);
    check("to_before_start", O_SM_START, 1);
    check("to_before_err", O_ERR, 0);
    @(negedge I_CLK);
    check("to_start", O_SM_START, 0);
    check("to_err", O_ERR, 1);
    check("to_busy", O_BUSY, 0);
    check("to_no_out", O_OUT_VLD, 0);
    pulse_row(1);
    check("to_err_clear", O_ERR, 0);
    I_RST = 1'b1;
    @(negedge I_CLK);
    I_RST = 1'b0;
    eng_mute = 1'b0;
    seen_max.delete();
    seen_sum.delete();
    @(negedge I_CLK);
`endif

    check("start_spacing_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
